// File: rtl/decode_stage.sv
// Instruction decode stage: a DEPTH-entry {inst, pc} FIFO whose head is decoded
// combinationally (RV32I/Zicsr/M) and captured into a valid/ready output register.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int EN_M  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      reg1_raddr_o,
  output logic [4:0]      reg2_raddr_o,
  input  logic [XLEN-1:0] reg1_rdata_i,
  input  logic [XLEN-1:0] reg2_rdata_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic [XLEN-1:0] csr_raddr_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] reg1_rdata_o,
  output logic [XLEN-1:0] reg2_rdata_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic [XLEN-1:0] csr_waddr_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic            csr_we_o,
  output logic            illegal_o
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic       HAS_M    = (EN_M != 32'd0);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MUL     = 7'b0000001;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] rs1d;
    logic [XLEN-1:0] rs2d;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] csrd;
    logic [XLEN-1:0] csrwa;
    logic            reg_we;
    logic [4:0]      waddr;
    logic            csr_we;
    logic            illegal;
  } dec_t;

  logic [31:0]     inst_mem_q [DEPTH];
  logic [XLEN-1:0] addr_mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  dec_t            dec_q, dec_d, head_dec_s;
  logic            push_s, pop_s;

  logic [31:0]     head_inst_s;
  logic [XLEN-1:0] head_addr_s;
  logic [6:0]      opc_s, f7_s;
  logic [2:0]      f3_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s, zimm_s;
  logic [XLEN-1:0] op1_s, op2_s, sd_s;
  logic            ill_s, we_s, cwe_s, use1_s, use2_s;

  assign in_ready_o = (cnt_q != FULL_CNT);
  assign push_s     = in_valid_i & in_ready_o & ~flush_i;
  assign pop_s      = (cnt_q != {(PW+1){1'b0}}) & (~out_valid_q | out_ready_i) & ~flush_i;

  assign head_inst_s = inst_mem_q[rd_ptr_q];
  assign head_addr_s = addr_mem_q[rd_ptr_q];
  assign opc_s       = head_inst_s[6:0];
  assign rd_s        = head_inst_s[11:7];
  assign f3_s        = head_inst_s[14:12];
  assign f7_s        = head_inst_s[31:25];

  // Casting a signed value to XLEN sign-extends without zero-width replications.
  assign imm_i_s = XLEN'($signed(head_inst_s[31:20]));
  assign imm_s_s = XLEN'($signed({head_inst_s[31:25], head_inst_s[11:7]}));
  assign imm_b_s = XLEN'($signed({head_inst_s[31], head_inst_s[7], head_inst_s[30:25],
                                  head_inst_s[11:8], 1'b0}));
  assign imm_j_s = XLEN'($signed({head_inst_s[31], head_inst_s[19:12], head_inst_s[20],
                                  head_inst_s[30:21], 1'b0}));
  assign imm_u_s = XLEN'($signed({head_inst_s[31:12], 12'b0}));
  assign zimm_s  = XLEN'(head_inst_s[19:15]);

  assign reg1_raddr_o = use1_s ? head_inst_s[19:15] : 5'd0;
  assign reg2_raddr_o = use2_s ? head_inst_s[24:20] : 5'd0;
  assign csr_raddr_o  = XLEN'(head_inst_s[31:20]);

  // Head decode: legality, register usage and operand selection.
  always_comb begin
    ill_s  = 1'b0;
    we_s   = 1'b0;
    cwe_s  = 1'b0;
    use1_s = 1'b0;
    use2_s = 1'b0;
    op1_s  = {XLEN{1'b0}};
    op2_s  = {XLEN{1'b0}};
    sd_s   = {XLEN{1'b0}};
    case (opc_s)
      OPC_LUI:    begin we_s = 1'b1; op1_s = imm_u_s; end
      OPC_AUIPC:  begin we_s = 1'b1; op1_s = head_addr_s; op2_s = imm_u_s; end
      OPC_JAL:    begin we_s = 1'b1; op1_s = head_addr_s; op2_s = imm_j_s; end
      OPC_JALR: begin
        we_s = 1'b1; use1_s = 1'b1; op1_s = reg1_rdata_i; op2_s = imm_i_s;
        ill_s = (f3_s != 3'b000);
      end
      OPC_BRANCH: begin
        use1_s = 1'b1; use2_s = 1'b1; op1_s = head_addr_s; op2_s = imm_b_s;
        ill_s = (f3_s[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        we_s = 1'b1; use1_s = 1'b1; op1_s = reg1_rdata_i; op2_s = imm_i_s;
        ill_s = (f3_s == 3'b011) | (f3_s[2:1] == 2'b11);
      end
      OPC_STORE: begin
        use1_s = 1'b1; use2_s = 1'b1; op1_s = reg1_rdata_i; op2_s = imm_s_s; sd_s = reg2_rdata_i;
        ill_s = f3_s[2] | (f3_s[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        we_s = 1'b1; use1_s = 1'b1; op1_s = reg1_rdata_i; op2_s = imm_i_s;
        ill_s = ((f3_s == 3'b001) & (f7_s != F7_ZERO)) |
                ((f3_s == 3'b101) & (f7_s != F7_ZERO) & (f7_s != F7_ALT));
      end
      OPC_OP: begin
        we_s = 1'b1; use1_s = 1'b1; use2_s = 1'b1; op1_s = reg1_rdata_i; op2_s = reg2_rdata_i;
        case (f7_s)
          F7_ZERO: ill_s = 1'b0;
          F7_ALT:  ill_s = (f3_s != 3'b000) & (f3_s != 3'b101);
          F7_MUL:  ill_s = ~HAS_M;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_FENCE:  ill_s = (f3_s[2:1] != 2'b00);
      OPC_SYSTEM: begin
        case (f3_s)
          3'b000:  ill_s = 1'b0;
          3'b100:  ill_s = 1'b1;
          default: begin
            cwe_s  = 1'b1;
            we_s   = 1'b1;
            use1_s = ~f3_s[2];
            op1_s  = f3_s[2] ? zimm_s : reg1_rdata_i;
          end
        endcase
      end
      default: ill_s = 1'b1;
    endcase

    head_dec_s.inst    = head_inst_s;
    head_dec_s.addr    = head_addr_s;
    head_dec_s.op1     = ill_s ? {XLEN{1'b0}} : op1_s;
    head_dec_s.op2     = ill_s ? {XLEN{1'b0}} : op2_s;
    head_dec_s.rs1d    = reg1_rdata_i;
    head_dec_s.rs2d    = reg2_rdata_i;
    head_dec_s.sdata   = ill_s ? {XLEN{1'b0}} : sd_s;
    head_dec_s.csrd    = csr_rdata_i;
    head_dec_s.csrwa   = (cwe_s & ~ill_s) ? XLEN'(head_inst_s[31:20]) : {XLEN{1'b0}};
    head_dec_s.reg_we  = we_s & ~ill_s & (rd_s != 5'd0);
    head_dec_s.waddr   = rd_s;
    head_dec_s.csr_we  = cwe_s & ~ill_s;
    head_dec_s.illegal = ill_s;
  end

  // Pointer, occupancy and output-stage next state; flush empties everything.
  always_comb begin
    wr_ptr_d    = push_s ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
    out_valid_d = pop_s ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
    dec_d       = pop_s ? head_dec_s : dec_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1'b1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1'b1);
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_ptr_d    = {PW{1'b0}};
      rd_ptr_d    = {PW{1'b0}};
      cnt_d       = {(PW+1){1'b0}};
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_d;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      cnt_q       <= {(PW+1){1'b0}};
      out_valid_q <= 1'b0;
      dec_q       <= dec_t'({$bits(dec_t){1'b0}});
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      inst_mem_q[wr_ptr_q] <= inst_i;
      addr_mem_q[wr_ptr_q] <= inst_addr_i;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign op1_o        = dec_q.op1;
  assign op2_o        = dec_q.op2;
  assign reg1_rdata_o = dec_q.rs1d;
  assign reg2_rdata_o = dec_q.rs2d;
  assign store_data_o = dec_q.sdata;
  assign csr_rdata_o  = dec_q.csrd;
  assign csr_waddr_o  = dec_q.csrwa;
  assign inst_o       = dec_q.inst;
  assign inst_addr_o  = dec_q.addr;
  assign reg_we_o     = dec_q.reg_we;
  assign reg_waddr_o  = dec_q.waddr;
  assign csr_we_o     = dec_q.csr_we;
  assign illegal_o    = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance (XLEN 32, DEPTH 2, M on)
// and a wide instance (XLEN 64, DEPTH 4, M off) behind small regfile/CSR models.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic [31:0] inst;
  logic [63:0] addr;
  int          checks = 0;
  int          failures = 0;
  int          acc;
  logic        rdy;

  logic        a_in_ready, a_ov, a_we, a_cwe, a_ill;
  logic [4:0]  a_r1a, a_r2a, a_waddr;
  logic [31:0] a_r1d, a_r2d, a_csrd_in, a_csra, a_op1, a_op2, a_rs1o, a_rs2o, a_sd, a_csrd, a_csrwa, a_inst, a_iaddr;

  logic        b_in_ready, b_ov, b_we, b_cwe, b_ill;
  logic [4:0]  b_r1a, b_r2a, b_waddr;
  logic [31:0] b_inst;
  logic [63:0] b_r1d, b_r2d, b_csrd_in, b_csra, b_op1, b_op2, b_rs1o, b_rs2o, b_sd, b_csrd, b_csrwa, b_iaddr;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf32(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : 32'h1000_0000 + {27'd0, a};
  endfunction
  function automatic logic [63:0] rf64(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : 64'hAAAA_0000_1000_0000 + {59'd0, a};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int imm);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = imm[11:0];
    r5  = rd[4:0];
    return {i12, 5'd0, 3'b000, r5, 7'h13};
  endfunction

  assign a_r1d     = rf32(a_r1a);
  assign a_r2d     = rf32(a_r2a);
  assign a_csrd_in = 32'hC000_0000 | a_csra;
  assign b_r1d     = rf64(b_r1a);
  assign b_r2d     = rf64(b_r2a);
  assign b_csrd_in = 64'hC000_0000_0000_0000 | b_csra;

  decode_stage u_dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid_a), .in_ready_o(a_in_ready),
    .inst_i(inst), .inst_addr_i(addr[31:0]), .reg1_raddr_o(a_r1a), .reg2_raddr_o(a_r2a),
    .reg1_rdata_i(a_r1d), .reg2_rdata_i(a_r2d), .csr_rdata_i(a_csrd_in), .csr_raddr_o(a_csra),
    .out_valid_o(a_ov), .out_ready_i(out_ready_a), .op1_o(a_op1), .op2_o(a_op2),
    .reg1_rdata_o(a_rs1o), .reg2_rdata_o(a_rs2o), .store_data_o(a_sd), .csr_rdata_o(a_csrd),
    .csr_waddr_o(a_csrwa), .inst_o(a_inst), .inst_addr_o(a_iaddr), .reg_we_o(a_we),
    .reg_waddr_o(a_waddr), .csr_we_o(a_cwe), .illegal_o(a_ill)
  );

  decode_stage #(.XLEN(64), .DEPTH(4), .EN_M(0)) u_dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid_b), .in_ready_o(b_in_ready),
    .inst_i(inst), .inst_addr_i(addr), .reg1_raddr_o(b_r1a), .reg2_raddr_o(b_r2a),
    .reg1_rdata_i(b_r1d), .reg2_rdata_i(b_r2d), .csr_rdata_i(b_csrd_in), .csr_raddr_o(b_csra),
    .out_valid_o(b_ov), .out_ready_i(out_ready_b), .op1_o(b_op1), .op2_o(b_op2),
    .reg1_rdata_o(b_rs1o), .reg2_rdata_o(b_rs2o), .store_data_o(b_sd), .csr_rdata_o(b_csrd),
    .csr_waddr_o(b_csrwa), .inst_o(b_inst), .inst_addr_o(b_iaddr), .reg_we_o(b_we),
    .reg_waddr_o(b_waddr), .csr_we_o(b_cwe), .illegal_o(b_ill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue_a(input logic [31:0] i, input logic [63:0] pc);
    inst = i; addr = pc; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick();
  endtask

  task automatic issue_b(input logic [31:0] i, input logic [63:0] pc);
    inst = i; addr = pc; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready_a = 1'b0; out_ready_b = 1'b1; inst = 32'd0; addr = 64'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", a_ov, 0);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_op2", a_op2, 0);
    chk("rst_inst", a_inst, 0);
    chk("rst_b_valid", b_ov, 0);
    chk("rst_b_op1", b_op1, 0);

    // ADDI x1,x0,5 at 0x100: one cycle in the FIFO, then staged
    out_ready_a = 1'b1; inst = 32'h0050_0093; addr = 64'h100; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    chk("addi_not_yet", a_ov, 0);
    tick();
    chk("addi_valid", a_ov, 1);
    chk("addi_op2", a_op2, 5);
    chk("addi_op1", a_op1, 0);
    chk("addi_we", a_we, 1);
    chk("addi_waddr", a_waddr, 1);
    chk("addi_ill", a_ill, 0);
    chk("addi_pc", a_iaddr, 64'h100);
    chk("addi_sd", a_sd, 0);
    tick();
    chk("drain_clear", a_ov, 0);

    issue_a(32'h0000_0013, 64'h104);
    chk("nop_we", a_we, 0);
    chk("nop_ill", a_ill, 0);

    issue_a(32'h0020_A423, 64'h108);            // sw x2,8(x1)
    chk("sw_op1", a_op1, 32'h1000_0001);
    chk("sw_op2", a_op2, 8);
    chk("sw_sd", a_sd, 32'h1000_0002);
    chk("sw_we", a_we, 0);

    issue_a(32'h3000_92F3, 64'h10C);            // csrrw x5,0x300,x1
    chk("csrrw_cwe", a_cwe, 1);
    chk("csrrw_waddr", a_csrwa, 32'h300);
    chk("csrrw_op1", a_op1, 32'h1000_0001);
    chk("csrrw_we", a_we, 1);
    chk("csrrw_rd", a_waddr, 5);
    chk("csrrw_rdata", a_csrd, 32'hC000_0300);

    issue_a(32'h3053_D073, 64'h110);            // csrrwi x0,0x305,7
    chk("csrrwi_op1", a_op1, 7);
    chk("csrrwi_cwe", a_cwe, 1);
    chk("csrrwi_we", a_we, 0);

    issue_a(32'h0FF0_000F, 64'h114);            // fence
    chk("fence_ill", a_ill, 0);
    chk("fence_cwe", a_cwe, 0);
    chk("fence_we", a_we, 0);

    issue_a(32'hFFFF_FFFF, 64'h118);
    chk("bad_valid", a_ov, 1);
    chk("bad_ill", a_ill, 1);
    chk("bad_op1", a_op1, 0);
    chk("bad_op2", a_op2, 0);
    chk("bad_we", a_we, 0);

    issue_a(32'h0220_81B3, 64'h11C);            // mul x3,x1,x2 with M enabled
    chk("mul_m_ill", a_ill, 0);
    chk("mul_m_we", a_we, 1);
    chk("mul_m_op2", a_op2, 32'h1000_0002);

    issue_a(32'hFFDF_F0EF, 64'h200);            // jal x1,-4
    chk("jal_op1", a_op1, 32'h200);
    chk("jal_op2", a_op2, 32'hFFFF_FFFC);
    chk("jal_we", a_we, 1);

    issue_b(32'h0220_81B3, 64'h400);            // mul with M disabled
    chk("mul_nom_ill", b_ill, 1);
    chk("mul_nom_we", b_we, 0);
    chk("mul_nom_op1", b_op1, 0);
    chk("mul_nom_op2", b_op2, 0);

    issue_b(32'hFFFF_F2B7, 64'h404);            // lui x5,0xFFFFF
    chk("lui64_op1", b_op1, 64'hFFFF_FFFF_FFFF_F000);
    chk("lui64_we", b_we, 1);
    chk("lui64_rd", b_waddr, 5);

    issue_b(32'hFFF0_0093, 64'h408);            // addi x1,x0,-1
    chk("addi64_op2", b_op2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi64_pc", b_iaddr, 64'h408);

    // Backpressure: DEPTH buffered + 1 staged, then drain in order
    out_ready_a = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      inst = addi(acc + 1, acc + 10); addr = 64'h500; in_valid_a = 1'b1;
      rdy = a_in_ready;
      tick();
      if (rdy) acc++;
    end
    in_valid_a = 1'b0;
    chk("bp_accepted", acc, 3);
    chk("bp_ready_low", a_in_ready, 0);
    chk("bp_valid", a_ov, 1);
    chk("bp_hold_inst", a_inst, addi(1, 10));
    chk("bp_hold_op2", a_op2, 10);
    out_ready_a = 1'b1;
    for (int j = 1; j < 3; j++) begin
      tick();
      chk("bp_order", a_inst, addi(j + 1, j + 10));
    end
    tick();
    chk("bp_empty", a_ov, 0);

    // Flush with FIFO full and output valid
    out_ready_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst = addi(k + 1, k + 20); in_valid_a = 1'b1;
      tick();
    end
    chk("fl_pre_valid", a_ov, 1);
    chk("fl_pre_full", a_in_ready, 0);
    flush = 1'b1; inst = addi(9, 99);
    tick();
    flush = 1'b0; in_valid_a = 1'b0;
    chk("fl_valid", a_ov, 0);
    chk("fl_ready", a_in_ready, 1);
    out_ready_a = 1'b1;
    tick();
    chk("fl_empty", a_ov, 0);
    flush = 1'b1; in_valid_a = 1'b1; inst = addi(9, 99);
    tick();
    flush = 1'b0; in_valid_a = 1'b0;
    tick();
    chk("fl_push_dropped", a_ov, 0);
    issue_a(addi(4, 44), 64'h300);
    chk("fl_after_valid", a_ov, 1);
    chk("fl_after_inst", a_inst, addi(4, 44));
    chk("fl_after_op2", a_op2, 44);

    // Reset mid-transfer beats flush and handshakes
    out_ready_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      inst = addi(k + 1, k + 30); addr = 64'h600; in_valid_a = 1'b1;
      tick();
    end
    chk("rs_pre_valid", a_ov, 1);
    rst = 1'b1; flush = 1'b1; in_valid_a = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid_a = 1'b0;
    chk("rs_valid", a_ov, 0);
    chk("rs_ready", a_in_ready, 1);
    chk("rs_inst", a_inst, 0);
    chk("rs_op2", a_op2, 0);
    chk("rs_waddr", a_waddr, 0);
    chk("rs_pc", a_iaddr, 0);
    chk("rs_we", a_we, 0);
    out_ready_a = 1'b1;
    tick();
    chk("rs_empty", a_ov, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
